// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: default geometry, the
// terminating instruction word and the loader FSM state encoding.
package program_loader_pkg;

  localparam int unsigned LEN_DEF            = 32;
  localparam int unsigned RAM_DEPTH_DEF      = 2048;
  localparam logic [31:0] HALT_INSTR_DEF     = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs received bytes big-endian into a 32-bit word. The completed word and
// its valid strobe are presented in the same cycle as the fourth byte so the
// loader can enter its write state on the following edge.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Shift in accepted bytes and count them; a load start clears both.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (byte_valid) begin
      word_d = {word_q[23:0], byte_data};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  // Shift register and byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word       = {word_q[23:0], byte_data};
  assign word_valid = byte_valid & ~clear & (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a program received as a byte stream into instruction memory, one
// 32-bit word per write, until the halt word is written or memory is full.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | after reset, waiting for i_start
//   ST_RECV  | collecting the four bytes of the next word
//   ST_WRITE | one-cycle memory write of the assembled word
//   ST_DONE  | halt word written, load complete
//   ST_ERR   | last address written without a halt word
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned      LEN               = LEN_DEF,
  parameter int unsigned      RAM_DEPTH_PROGRAM = RAM_DEPTH_DEF,
  parameter logic [LEN-1:0]   HALT_INSTR        = LEN'(HALT_INSTR_DEF)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [7:0]     i_rx_data,
  input  logic           i_rx_done,
  output logic           o_preload_flag,
  output logic [LEN-1:0] o_preload_address,
  output logic [LEN-1:0] o_preload_instruction,
  output logic           o_loading,
  output logic           o_load_done,
  output logic           o_overflow_err,
  output logic [LEN-1:0] o_word_count
);

  localparam logic [LEN-1:0] ADDR_LAST = LEN'(RAM_DEPTH_PROGRAM - 1);

  state_e         state_q, state_d;
  logic [LEN-1:0] addr_q, addr_d;
  logic [LEN-1:0] count_q, count_d;
  logic           flag_q, flag_d;
  logic [LEN-1:0] paddr_q, paddr_d;
  logic [LEN-1:0] pinstr_q, pinstr_d;

  logic        start_ok;
  logic        write_ends;
  logic        byte_accept;
  logic [31:0] asm_word;
  logic        asm_valid;

  // The write cycle already knows whether the load will terminate, so a byte
  // arriving then is kept only if reception continues.
  assign start_ok    = i_start & ((state_q == ST_IDLE) | (state_q == ST_DONE) |
                                  (state_q == ST_ERR));
  assign write_ends  = (pinstr_q == HALT_INSTR) | (addr_q == ADDR_LAST);
  assign byte_accept = i_rx_done & ((state_q == ST_RECV) |
                                    ((state_q == ST_WRITE) & ~write_ends));

  word_assembler u_word_assembler (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .clear      (start_ok),
    .byte_valid (byte_accept),
    .byte_data  (i_rx_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  // Next-state, address/count bookkeeping and registered write port.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    flag_d   = 1'b0;
    paddr_d  = paddr_q;
    pinstr_d = pinstr_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          state_d = ST_RECV;
          addr_d  = '0;
          count_d = '0;
        end
      end
      ST_RECV: begin
        if (asm_valid) begin
          state_d  = ST_WRITE;
          flag_d   = 1'b1;
          paddr_d  = addr_q;
          pinstr_d = LEN'(asm_word);
        end
      end
      ST_WRITE: begin
        count_d = count_q + LEN'(1);
        if (pinstr_q == HALT_INSTR) begin
          state_d = ST_DONE;
        end else if (addr_q == ADDR_LAST) begin
          state_d = ST_ERR;
        end else begin
          addr_d  = addr_q + LEN'(1);
          state_d = ST_RECV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      paddr_q  <= '0;
      pinstr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      paddr_q  <= paddr_d;
      pinstr_q <= pinstr_d;
    end
  end

  assign o_preload_flag        = flag_q;
  assign o_preload_address     = paddr_q;
  assign o_preload_instruction = pinstr_q;
  assign o_loading             = (state_q == ST_RECV) | (state_q == ST_WRITE);
  assign o_load_done           = (state_q == ST_DONE);
  assign o_overflow_err        = (state_q == ST_ERR);
  assign o_word_count          = count_q;

endmodule
